// File: rtl/jt10_adpcmb_nibdec_if.sv
// Request/result bundle between the ADPCM-B sequencer (master) and the nibble decoder (slave).
interface jt10_adpcmb_nibdec_if;
    logic               cen;
    logic               cen55;
    logic               adv;
    logic               chon;
    logic               clr;
    logic [3:0]         data;
    logic signed [15:0] pcm;
    logic               busy;
    logic               ovr;

    modport master (
        output cen, cen55, adv, chon, clr, data,
        input  pcm, busy, ovr
    );

    modport slave (
        input  cen, cen55, adv, chon, clr, data,
        output pcm, busy, ovr
    );
endinterface

// File: rtl/jt10_adpcmb_nibdec.sv
// ADPCM-B nibble decoder: bit-serial step*factor products on cen, one code per request,
// saturating 16-bit pcm and a step size clamped to [STEP_MIN, STEP_MAX].
module jt10_adpcmb_nibdec #(
    parameter int STEP_MIN = 127,
    parameter int STEP_MAX = 24576
) (
    input logic                 clk,
    input logic                 rst,
    jt10_adpcmb_nibdec_if.slave bus
);

    typedef enum logic [2:0] {IDLE, MULD, ACC, MULS, STEP} state_t;

    state_t             st_q, st_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [3:0]         nib_q, nib_d;
    logic [14:0]        step_q, step_d;
    logic signed [15:0] pcm_q, pcm_d;
    logic [22:0]        acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;

    logic               req;
    logic [7:0]         factor;
    logic [22:0]        partial;
    logic [22:0]        acc_sum;
    logic [16:0]        diff;
    logic signed [17:0] sum;

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic [14:0] clamp_step(input logic [16:0] v);
        if (v < 17'(STEP_MIN))
            return 15'(STEP_MIN);
        else if (v > 17'(STEP_MAX))
            return 15'(STEP_MAX);
        else
            return v[14:0];
    endfunction

    function automatic logic [7:0] step_mult(input logic [2:0] m);
        case (m)
            3'd4:    return 8'd77;
            3'd5:    return 8'd102;
            3'd6:    return 8'd128;
            3'd7:    return 8'd153;
            default: return 8'd57;
        endcase
    endfunction

    assign req = bus.cen55 & bus.adv & bus.chon;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        nib_d  = nib_q;
        step_d = step_q;
        pcm_d  = pcm_q;
        acc_d  = acc_q;
        busy_d = busy_q;
        ovr_d  = ovr_q;

        // The single shared adder: add step<<cnt when the scanned factor bit is set
        factor  = (st_q == MULS) ? step_mult(nib_q[2:0]) : {4'd0, nib_q[2:0], 1'b1};
        partial = factor[cnt_q] ? ({8'd0, step_q} << cnt_q) : 23'd0;
        acc_sum = acc_q + partial;

        diff = {1'b0, acc_q[18:3]};
        sum  = nib_q[3] ? ($signed({{2{pcm_q[15]}}, pcm_q}) - $signed({1'b0, diff}))
                        : ($signed({{2{pcm_q[15]}}, pcm_q}) + $signed({1'b0, diff}));

        if (st_q == IDLE) begin
            if (req) begin
                nib_d  = bus.data;
                busy_d = 1'b1;
                cnt_d  = 3'd0;
                acc_d  = 23'd0;
                st_d   = MULD;
            end
        end else begin
            if (req)
                ovr_d = 1'b1;
            if (bus.cen) begin
                case (st_q)
                    MULD: begin
                        acc_d = acc_sum;
                        cnt_d = 3'(cnt_q + 3'd1);
                        if (cnt_q == 3'd3)
                            st_d = ACC;
                    end
                    ACC: begin
                        pcm_d = sat16(sum);
                        acc_d = 23'd0;
                        cnt_d = 3'd0;
                        st_d  = MULS;
                    end
                    MULS: begin
                        acc_d = acc_sum;
                        cnt_d = 3'(cnt_q + 3'd1);
                        if (cnt_q == 3'd7)
                            st_d = STEP;
                    end
                    STEP: begin
                        step_d = clamp_step(acc_q[22:6]);
                        busy_d = 1'b0;
                        st_d   = IDLE;
                    end
                    default: st_d = IDLE;
                endcase
            end
        end
    end

    // nib/acc/cnt are always reloaded at capture, so only the architectural state is reset
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            st_q   <= IDLE;
            step_q <= 15'(STEP_MIN);
            pcm_q  <= 16'sd0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            step_q <= step_d;
            pcm_q  <= pcm_d;
            busy_q <= busy_d;
            ovr_q  <= ovr_d;
        end
        cnt_q <= cnt_d;
        nib_q <= nib_d;
        acc_q <= acc_d;
    end

    assign bus.pcm  = pcm_q;
    assign bus.busy = busy_q;
    assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_jt10_adpcmb_nibdec.sv
// Bench for the ADPCM-B nibble decoder: hand-computed vector table, timing and
// overrun corner sequences, and randomized codes against an integer reference model.
module tb_jt10_adpcmb_nibdec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt10_adpcmb_nibdec_if bus();

    jt10_adpcmb_nibdec #(.STEP_MIN(127), .STEP_MAX(24576)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: decoded sample and step size as plain integers
    int m_pcm  = 0;
    int m_step = 127;

    typedef struct {
        bit       do_rst;
        bit [3:0] code;
        int       exp_pcm;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int mult_of(input int m);
        case (m)
            4: return 77;
            5: return 102;
            6: return 128;
            7: return 153;
            default: return 57;
        endcase
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_decode(input bit [3:0] code);
        int mag;
        int d;
        mag = int'(code[2:0]);
        d = (m_step * (2 * mag + 1)) / 8;
        m_pcm  = clampi(code[3] ? m_pcm - d : m_pcm + d, -32768, 32767);
        m_step = clampi((m_step * mult_of(mag)) / 64, 127, 24576);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_pcm  = 0;
        m_step = 127;
    endtask

    // Issue one request then clock until busy falls; reports cen counts to pcm change and busy fall
    task automatic send(input bit [3:0] code, input int gap_pct, output int t_pcm, output int t_busy);
        logic signed [15:0] p0;
        logic c;
        int ncen;
        p0 = bus.pcm;
        bus.data  = code;
        bus.adv   = 1'b1;
        bus.cen55 = 1'b1;
        bus.cen   = 1'b1;
        cyc();
        bus.adv   = 1'b0;
        bus.cen55 = 1'b0;
        check("busy_after_capture", int'(bus.busy), 1);
        ncen   = 0;
        t_pcm  = -1;
        t_busy = -1;
        for (int i = 0; i < 4000; i++) begin
            bus.cen = ($urandom_range(0, 99) >= gap_pct);
            c = bus.cen;
            cyc();
            if (c) ncen++;
            if (t_pcm < 0 && bus.pcm !== p0) t_pcm = ncen;
            if (!bus.busy) begin
                t_busy = ncen;
                break;
            end
        end
        bus.cen = 1'b0;
        if (t_busy < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: got busy stuck high, expected fall within 4000 cycles");
        end
    endtask

    task automatic run_to_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus.cen = 1'b1;
            cyc();
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        bus.cen = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got busy stuck high, expected fall within 4000 cycles");
        end
    endtask

    initial begin
        int tp, tb;
        bit any_busy;
        bit [3:0] code;

        bus.cen = 1'b0; bus.cen55 = 1'b0; bus.adv = 1'b0;
        bus.chon = 1'b1; bus.clr = 1'b0; bus.data = 4'd0;

        vecs[0] = '{1'b1, 4'h7,   238};
        vecs[1] = '{1'b0, 4'h7,   806};
        vecs[2] = '{1'b0, 4'hF,  -551};
        vecs[3] = '{1'b0, 4'h0,  -335};
        vecs[4] = '{1'b1, 4'h8,   -15};
        vecs[5] = '{1'b0, 4'h4,   127};
        vecs[6] = '{1'b0, 4'hC,   -44};
        vecs[7] = '{1'b1, 4'h0,    15};

        repeat (2) cyc();
        do_reset();
        check("reset_pcm", int'(bus.pcm), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_ovr", int'(bus.ovr), 0);

        // Hand-computed decode vectors
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            send(vecs[i].code, 0, tp, tb);
            model_decode(vecs[i].code);
            check($sformatf("vec%0d_pcm", i), int'(bus.pcm), vecs[i].exp_pcm);
            check($sformatf("vec%0d_model", i), m_pcm, vecs[i].exp_pcm);
        end

        // Positive then negative saturation
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(4'h7, 0, tp, tb);
            model_decode(4'h7);
            check("sat_up_pcm", int'(bus.pcm), m_pcm);
        end
        check("sat_up_final", int'(bus.pcm), 32767);
        send(4'hF, 0, tp, tb);
        model_decode(4'hF);
        check("sat_first_down", int'(bus.pcm), -13313);
        for (int i = 0; i < 4; i++) begin
            send(4'hF, 0, tp, tb);
            model_decode(4'hF);
            check("sat_down_pcm", int'(bus.pcm), m_pcm);
        end
        check("sat_down_final", int'(bus.pcm), -32768);

        // Latency in cen edges, continuous and with random cen gaps
        do_reset();
        send(4'h7, 0, tp, tb);
        model_decode(4'h7);
        check("lat_pcm_cen", tp, 5);
        check("lat_busy_cen", tb, 14);
        for (int i = 0; i < 4; i++) begin
            code = 4'($urandom_range(1, 7));
            send(code, 70, tp, tb);
            model_decode(code);
            check("gap_lat_pcm", tp, 5);
            check("gap_lat_busy", tb, 14);
            check("gap_pcm", int'(bus.pcm), m_pcm);
        end
        check("ovr_clean", int'(bus.ovr), 0);

        // Second request 3 cen after the first is dropped
        do_reset();
        bus.data = 4'h7; bus.adv = 1'b1; bus.cen55 = 1'b1; bus.cen = 1'b1;
        cyc();
        bus.adv = 1'b0; bus.cen55 = 1'b0;
        repeat (3) cyc();
        bus.cen = 1'b0; bus.data = 4'h0; bus.adv = 1'b1; bus.cen55 = 1'b1;
        cyc();
        bus.adv = 1'b0; bus.cen55 = 1'b0;
        check("ovr_set", int'(bus.ovr), 1);
        run_to_idle();
        check("ovr_pcm", int'(bus.pcm), 238);
        check("ovr_sticky", int'(bus.ovr), 1);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        check("clr_ovr", int'(bus.ovr), 0);
        check("clr_pcm", int'(bus.pcm), 0);
        send(4'h7, 0, tp, tb);
        check("clr_step", int'(bus.pcm), 238);

        // Request coincident with the STEP cen
        do_reset();
        bus.data = 4'h7; bus.adv = 1'b1; bus.cen55 = 1'b1; bus.cen = 1'b0;
        cyc();
        bus.adv = 1'b0; bus.cen55 = 1'b0; bus.cen = 1'b1;
        repeat (13) cyc();
        check("step_busy", int'(bus.busy), 1);
        bus.data = 4'h0; bus.adv = 1'b1; bus.cen55 = 1'b1;
        cyc();
        bus.adv = 1'b0; bus.cen55 = 1'b0;
        check("step_req_busy", int'(bus.busy), 0);
        check("step_req_ovr", int'(bus.ovr), 1);
        repeat (3) cyc();
        bus.cen = 1'b0;
        check("step_req_dropped", int'(bus.busy), 0);
        check("step_req_pcm", int'(bus.pcm), 238);

        // Reset in the middle of MULS
        do_reset();
        bus.data = 4'h7; bus.adv = 1'b1; bus.cen55 = 1'b1; bus.cen = 1'b1;
        cyc();
        bus.adv = 1'b0; bus.cen55 = 1'b0;
        repeat (8) cyc();
        check("muls_pcm_before", int'(bus.pcm), 238);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.cen = 1'b0;
        check("muls_rst_busy", int'(bus.busy), 0);
        check("muls_rst_pcm", int'(bus.pcm), 0);
        m_pcm = 0; m_step = 127;

        // chon=0: requests ignored, pcm holds
        send(4'h7, 0, tp, tb);
        model_decode(4'h7);
        bus.chon = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.data = 4'hF; bus.adv = 1'b1; bus.cen55 = 1'b1; bus.cen = 1'b1;
            cyc();
            if (bus.busy) any_busy = 1'b1;
        end
        bus.adv = 1'b0; bus.cen55 = 1'b0; bus.cen = 1'b0;
        bus.chon = 1'b1;
        check("chon_busy", int'(any_busy), 0);
        check("chon_pcm", int'(bus.pcm), 238);
        check("chon_ovr", int'(bus.ovr), 0);

        // Randomized codes against the reference model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            code = 4'($urandom_range(0, 15));
            send(code, 30, tp, tb);
            model_decode(code);
            check("rand_pcm", int'(bus.pcm), m_pcm);
            if (($urandom_range(0, 19)) == 0) begin
                bus.clr = 1'b1;
                cyc();
                bus.clr = 1'b0;
                m_pcm = 0; m_step = 127;
                check("rand_clr_pcm", int'(bus.pcm), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jt10_adpcmb_nibdec.md
Name: jt10_adpcmb_nibdec

Overview:
- ADPCM-B (YM2610 delta-T) nibble decoder, directly upstream of the ADPCM-B interpolator.
- Consumes one 4-bit code per 55 kHz advance and produces the signed 16-bit decoded sample the interpolator latches as its raw input.
- Arithmetic is bit-serial on the 8 MHz cen: one adder, no hard multiplier.

Parameters:
- STEP_MIN, 127, lower clamp and reset value of the step size.
- STEP_MAX, 24576, upper clamp of the step size.

Ports:
- clk    in   1   system clock
- rst    in   1   synchronous reset, active-high
- cen    in   1   8 MHz clock enable; FSM advances only on clk&cen
- cen55  in   1   55 kHz clock enable
- adv    in   1   request next code; sampled when cen55=1
- chon   in   1   channel on; when 0, requests are ignored
- clr    in   1   synchronous decoder restart (new sample start)
- data   in   4   ADPCM code: bit3 = sign, bits2:0 = magnitude
- pcm    out  16  signed decoded sample (two's complement)
- busy   out  1   decode in progress
- ovr    out  1   sticky: a request arrived while busy

Behaviour:
- Interface rule: one clock, clk; reset rst is synchronous, active-high.
- Reset values (rst or clr): pcm=0, step=STEP_MIN, busy=0, ovr=0, FSM=IDLE. Any operation in flight is aborted.
- Priority in one cycle: rst > clr > request.
- Request:
  - A request is cen55&adv&chon on any clk edge, independent of cen.
  - In IDLE: latch data into nib, set busy=1, go to MULD.
  - While busy: the request is dropped, nib is unchanged, ovr<=1.
  - ovr clears only on rst or clr.
- FSM (each transition below occurs only on clk&cen):
  - MULD, 4 cen: serial product prod = step*(2*nib[2:0]+1), scanning factor bits LSB first. prod is 19 bits unsigned.
  - ACC, 1 cen:
    - diff = prod>>3 (17 bits unsigned).
    - sum = pcm - diff if nib[3], else pcm + diff (18 bits signed).
    - Saturate sum to [-32768, 32767] and write it to pcm.
  - MULS, 8 cen: serial product sp = step*mult (23 bits). mult is indexed by nib[2:0]: 57, 57, 57, 57, 77, 102, 128, 153.
  - STEP, 1 cen: step <= clamp(sp>>6, STEP_MIN, STEP_MAX). Then busy<=0 and go to IDLE.
- Latency: pcm changes at the end of the 5th cen after capture. busy falls at the end of the 14th cen.
- Headroom: the next request must come at least 14 cen later; 55 kHz gives about 145 cen, ample.
- pcm changes only in ACC, rst or clr. It holds otherwise, including when chon=0.
- cen held low stalls the FSM indefinitely. No state is lost.
- A request coincident with the STEP cen is dropped and sets ovr, because busy is still 1.
- Arithmetic is unsigned except sum and pcm.
- step never leaves [STEP_MIN, STEP_MAX], and it stays in range after saturation.

Test Plan:
1. rst, then code 0x7 -> pcm=238, step=303. Then a second 0x7 -> pcm=806, step=724.
2. From reset, code 0x8 -> pcm=-15. The raw step (113) clamps to 127.
3. 40 consecutive 0x7 codes -> step saturates at 24576; pcm saturates at 32767 and stays there. Then 0xF codes -> pcm decreases from 32767 with no wrap; continuing drives it to -32768 and holds.
4. Measure timing from request to pcm change and to busy fall -> exactly 5 and 14 cen edges. Insert cen gaps of random length -> same values, stretched timing.
5. A second request 3 cen after the first -> ovr=1 and the result equals the single-code result. Then clr -> ovr=0, pcm=0, step=127.
6. Assert rst mid-MULS -> next cycle busy=0, pcm=0. With chon=0 plus requests -> busy stays 0 and pcm is unchanged.
